// File: rtl/delay_sched_pkg.sv
// Shared definitions for the delay-timer scheduler and its round-robin picker.
//   state_t  : scheduler FSM encoding (IDLE, COUNT)
//   pick_t   : result of a round-robin scan (valid + winning index)
//   rr_pick  : scan req starting just after 'last', wrapping modulo nreq
package delay_sched_pkg;

  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefCbits = 18;

  // Upper bound on requesters; sizes the generic picker function.
  localparam int unsigned MaxReq  = 8;
  localparam int unsigned MaxIdxW = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] idx;
  } pick_t;

  // First asserted req scanning last+1, last+2, ... (mod nreq). The previous
  // winner is visited last, so it has lowest priority.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0]  req,
                                    input logic [MaxIdxW-1:0] last,
                                    input int unsigned        nreq);
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      i = (32'(last) + k) % nreq;
      if (!p.valid && (k <= nreq) && req[i[MaxIdxW-1:0]]) begin
        p.valid = 1'b1;
        p.idx   = i[MaxIdxW-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/delay_sched_if.sv
// Client-side bundle of the delay scheduler.
//   req  : per-requester request level
//   len  : per-requester delay length, slice i = len[i*CBITS +: CBITS]
//   gnt  : one-hot timer owner
//   done : one-cycle expiry pulse to the owner
//   busy : timer owned
//   cnt  : current counter value
//   err  : sticky overrun flag
// master = client side, slave = scheduler side.
interface delay_sched_if import delay_sched_pkg::*; #(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned CBITS = DefCbits
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [CBITS-1:0]      cnt;
  logic                  err;

  modport master (
    output req, len,
    input  gnt, done, busy, cnt, err
  );

  modport slave (
    input  req, len,
    output gnt, done, busy, cnt, err
  );

endinterface

// File: rtl/delay_rr_arb.sv
// Combinational round-robin picker for shared-resource schedulers.
//   req_i    : request vector
//   last_i   : index of the previous winner (lowest priority this round)
//   onehot_o : one-hot winner, zero when no request
//   index_o  : winner index (valid only with valid_o)
//   valid_o  : at least one request present
module delay_rr_arb import delay_sched_pkg::*; #(
  parameter int unsigned NREQ = DefNreq
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic [NREQ-1:0]         onehot_o,
  output logic [$clog2(NREQ)-1:0] index_o,
  output logic                    valid_o
);

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [MaxReq-1:0] req_ext;
  pick_t             pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req_i;
    pick               = rr_pick(req_ext, MaxIdxW'(last_i), NREQ);
    valid_o            = pick.valid;
    index_o            = IdxW'(pick.idx);
    onehot_o           = '0;
    if (pick.valid) begin
      onehot_o[index_o] = 1'b1;
    end
  end

endmodule

// File: rtl/delay_sched.sv
// Shared delay-timer scheduler: NREQ clients take turns on one CBITS-wide
// up-counter. An idle cycle arbitrates round-robin; the winner's length is
// latched as the target and the counter runs 0..target, then the owner gets
// a one-cycle done pulse. Dropping req while owning abandons the delay.
//   clk, rst : clock, synchronous active-high reset
//   bus      : delay_sched_if slave (req/len in, gnt/done/busy/cnt/err out)
module delay_sched import delay_sched_pkg::*; #(
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned CBITS = DefCbits
) (
  input logic          clk,
  input logic          rst,
  delay_sched_if.slave bus
);

  localparam int unsigned IdxW    = $clog2(NREQ);
  localparam logic [0:0]  StIdle  = IDLE;
  localparam logic [0:0]  StCount = COUNT;

  logic [0:0]            state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       done_q, done_d;
  logic [CBITS-1:0]      cnt_q, cnt_d;
  logic [CBITS-1:0]      tgt_q, tgt_d;
  logic [IdxW-1:0]       last_q, last_d;
  logic                  err_q, err_d;

  logic [NREQ-1:0]       req;
  logic [NREQ*CBITS-1:0] len;
  logic [NREQ-1:0]       pick_onehot;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_valid;
  logic                  busy;

  assign req  = bus.req;
  assign len  = bus.len;
  assign busy = (state_q == StCount);

  delay_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i    (req),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .index_o  (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    last_d  = last_q;
    // Termination compares against tgt, so this can only fire on a fault.
    err_d   = err_q | (busy && (cnt_q > tgt_q));

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = StCount;
          gnt_d   = pick_onehot;
          tgt_d   = len[pick_idx*CBITS +: CBITS];
          last_d  = pick_idx;
        end else begin
          gnt_d = '0;
        end
      end
      StCount: begin
        if ((req & gnt_q) == '0) begin
          // Owner abandoned the wait: release without a done pulse.
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q >= tgt_q) begin
          state_d = StIdle;
          gnt_d   = '0;
          cnt_d   = '0;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      last_q  <= IdxW'(NREQ - 1);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy;
  assign bus.cnt  = cnt_q;
  assign bus.err  = err_q;

  a_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt_q) && $onehot0(done_q));

  a_done_owner: assert property (@(posedge clk) disable iff (rst)
    !(|(done_q & ~$past(gnt_q))));

  a_noerr: assert property (@(posedge clk) disable iff (rst) !err_q);

  a_busy: assert property (@(posedge clk) disable iff (rst) busy == (gnt_q != '0));

`ifdef FORMAL
  // A requester that keeps asking is eventually served (or gives up).
  for (genvar i = 0; i < NREQ; i++) begin : g_fair
    l_fair: assert property (@(posedge clk) disable iff (rst)
      req[i] |-> s_eventually (done_q[i] || !req[i]));
  end
`endif

endmodule

// File: tb/tb_delay_sched.sv
module tb_delay_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  vec;
    int unsigned cyc;
  } ev_t;

  ev_t qa_gnt[$];
  ev_t qa_done[$];
  ev_t qb_gnt[$];
  ev_t qb_done[$];

  delay_sched_if #(.NREQ(4), .CBITS(18)) ia ();
  delay_sched_if #(.NREQ(2), .CBITS(4))  ib ();

  delay_sched #(.NREQ(4), .CBITS(18)) u_a (.clk(clk), .rst(rst), .bus(ia));
  delay_sched #(.NREQ(2), .CBITS(4))  u_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every new grant and every done pulse must match the next
  // expected event in order, including the cycle it appears in.
  logic [3:0] prev_ga = '0;
  logic [1:0] prev_gb = '0;

  always @(negedge clk) begin : mon
    ev_t e;
    if (ia.gnt != '0 && ia.gnt != prev_ga) begin
      if (qa_gnt.size() == 0) chk("a_gnt_unexpected", 32'(ia.gnt), 0);
      else begin
        e = qa_gnt.pop_front();
        chk("a_gnt_vec", 32'(ia.gnt), 32'(e.vec));
        chk("a_gnt_cyc", cyc, e.cyc);
      end
    end
    if (ia.done != '0) begin
      if (qa_done.size() == 0) chk("a_done_unexpected", 32'(ia.done), 0);
      else begin
        e = qa_done.pop_front();
        chk("a_done_vec", 32'(ia.done), 32'(e.vec));
        chk("a_done_cyc", cyc, e.cyc);
      end
    end
    if (ib.gnt != '0 && ib.gnt != prev_gb) begin
      if (qb_gnt.size() == 0) chk("b_gnt_unexpected", 32'(ib.gnt), 0);
      else begin
        e = qb_gnt.pop_front();
        chk("b_gnt_vec", 32'(ib.gnt), 32'(e.vec));
        chk("b_gnt_cyc", cyc, e.cyc);
      end
    end
    if (ib.done != '0) begin
      if (qb_done.size() == 0) chk("b_done_unexpected", 32'(ib.done), 0);
      else begin
        e = qb_done.pop_front();
        chk("b_done_vec", 32'(ib.done), 32'(e.vec));
        chk("b_done_cyc", cyc, e.cyc);
      end
    end
    prev_ga = ia.gnt;
    prev_gb = ib.gnt;
  end

  task automatic do_reset();
    ia.req = '0;
    ia.len = '0;
    ib.req = '0;
    ib.len = '0;
    rst    = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(ia.gnt), 0);
    chk("rst_done", 32'(ia.done), 0);
    chk("rst_busy", 32'(ia.busy), 0);
    chk("rst_cnt", 32'(ia.cnt), 0);
    chk("rst_err", 32'(ia.err), 0);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int unsigned k;

    // Single requester, len=5: done 6 cycles after grant.
    do_reset();
    ia.len[1*18 +: 18] = 18'd5;
    ia.req = 4'b0010;
    k = cyc;
    qa_gnt.push_back('{vec: 8'h02, cyc: k + 1});
    qa_done.push_back('{vec: 8'h02, cyc: k + 7});
    tick();
    chk("s1_busy", 32'(ia.busy), 1);
    chk("s1_cnt0", 32'(ia.cnt), 0);
    tick();
    tick();
    chk("s1_cnt2", 32'(ia.cnt), 2);
    repeat (4) tick();
    chk("s1_done", 32'(ia.done), 32'h2);
    chk("s1_busy_fall", 32'(ia.busy), 0);
    chk("s1_cnt_clr", 32'(ia.cnt), 0);
    ia.req = '0;
    tick();
    chk("s1_done_once", 32'(ia.done), 0);
    chk("s1_gnt_idle", 32'(ia.gnt), 0);

    // Round-robin: all request, len=2, order 0,1,2,3,0 every 4 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) ia.len[i*18 +: 18] = 18'd2;
    ia.req = 4'hF;
    k = cyc;
    for (int j = 0; j < 5; j++) begin
      qa_gnt.push_back('{vec: 8'(1 << (j % 4)), cyc: k + 1 + 4 * j});
      qa_done.push_back('{vec: 8'(1 << (j % 4)), cyc: k + 4 + 4 * j});
    end
    repeat (20) tick();
    ia.req = '0;
    tick();
    chk("s2_gnt_idle", 32'(ia.gnt), 0);
    chk("s2_busy_idle", 32'(ia.busy), 0);

    // Zero length: done one cycle after grant.
    do_reset();
    ia.len[2*18 +: 18] = 18'd0;
    ia.req = 4'b0100;
    k = cyc;
    qa_gnt.push_back('{vec: 8'h04, cyc: k + 1});
    qa_done.push_back('{vec: 8'h04, cyc: k + 2});
    tick();
    chk("s3_gnt", 32'(ia.gnt), 32'h4);
    tick();
    chk("s3_done", 32'(ia.done), 32'h4);
    ia.req = '0;
    tick();
    chk("s3_err", 32'(ia.err), 0);

    // Abort: req[0] dropped after 4 COUNT cycles, pending req[3] served.
    do_reset();
    ia.len[0*18 +: 18] = 18'd10;
    ia.len[3*18 +: 18] = 18'd1;
    ia.req = 4'b1001;
    k = cyc;
    qa_gnt.push_back('{vec: 8'h01, cyc: k + 1});
    qa_gnt.push_back('{vec: 8'h08, cyc: k + 6});
    qa_done.push_back('{vec: 8'h08, cyc: k + 8});
    repeat (4) tick();
    chk("s4_cnt3", 32'(ia.cnt), 3);
    ia.req = 4'b1000;
    tick();
    chk("s4_abort_gnt", 32'(ia.gnt), 0);
    chk("s4_abort_busy", 32'(ia.busy), 0);
    chk("s4_abort_done", 32'(ia.done), 0);
    tick();
    chk("s4_gnt3", 32'(ia.gnt), 32'h8);
    tick();
    tick();
    chk("s4_done3", 32'(ia.done), 32'h8);
    ia.req = '0;
    tick();

    // Reset mid-count at cnt=7; afterwards req[0] beats req[1].
    do_reset();
    ia.len[2*18 +: 18] = 18'd20;
    ia.len[0*18 +: 18] = 18'd1;
    ia.len[1*18 +: 18] = 18'd0;
    ia.req = 4'b0100;
    k = cyc;
    qa_gnt.push_back('{vec: 8'h04, cyc: k + 1});
    repeat (8) tick();
    chk("s5_cnt7", 32'(ia.cnt), 7);
    rst    = 1'b1;
    ia.req = 4'b0011;
    tick();
    chk("s5_rst_gnt", 32'(ia.gnt), 0);
    chk("s5_rst_busy", 32'(ia.busy), 0);
    chk("s5_rst_cnt", 32'(ia.cnt), 0);
    chk("s5_rst_done", 32'(ia.done), 0);
    rst = 1'b0;
    k = cyc;
    qa_gnt.push_back('{vec: 8'h01, cyc: k + 1});
    qa_done.push_back('{vec: 8'h01, cyc: k + 3});
    qa_gnt.push_back('{vec: 8'h02, cyc: k + 4});
    qa_done.push_back('{vec: 8'h02, cyc: k + 5});
    tick();
    chk("s5_gnt0", 32'(ia.gnt), 32'h1);
    tick();
    tick();
    chk("s5_done0", 32'(ia.done), 32'h1);
    ia.req = 4'b0010;
    tick();
    chk("s5_gnt1", 32'(ia.gnt), 32'h2);
    tick();
    chk("s5_done1", 32'(ia.done), 32'h2);
    ia.req = '0;
    tick();

    // Max length on a 4-bit counter: 0..15, done 16 cycles after grant.
    do_reset();
    ib.len[3:0] = 4'd15;
    ib.req = 2'b01;
    k = cyc;
    qb_gnt.push_back('{vec: 8'h01, cyc: k + 1});
    qb_done.push_back('{vec: 8'h01, cyc: k + 17});
    repeat (16) tick();
    chk("s6_cnt15", 32'(ib.cnt), 15);
    chk("s6_busy", 32'(ib.busy), 1);
    chk("s6_err_run", 32'(ib.err), 0);
    tick();
    chk("s6_done", 32'(ib.done), 32'h1);
    chk("s6_cnt_clr", 32'(ib.cnt), 0);
    chk("s6_err_end", 32'(ib.err), 0);
    ib.req = '0;
    tick();
    tick();

    chk("a_gnt_pending", qa_gnt.size(), 0);
    chk("a_done_pending", qa_done.size(), 0);
    chk("b_gnt_pending", qb_gnt.size(), 0);
    chk("b_done_pending", qb_done.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
